// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - memory-stage exception/ERET commit, pipeline flush and fetch redirect sequencer
//
// Ports:
//   clk, reset                  sole clock (rising edge), asynchronous active-high reset
//   m_valid, m_pc, m_bd         memory-stage instruction, its PC and delay-slot flag
//   m_exc_*                     per-source exception flags from the pipeline
//   m_vaddr                     data virtual address of the load/store
//   m_eret, int_pending, epc    ERET marker, CP0 interrupt request, current CP0 EPC
//   m_ready                     high only while idle and able to accept an instruction
//   exc_valid/eret_commit       one-cycle commit pulses to CP0
//   exc_code/pc/bd/badvaddr     exception record to CP0, held until the next accept
//   flush                       kill younger stages for the whole sequence
//   redirect_valid/pc/ready     new fetch PC handshake with the fetch stage

module exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic        m_exc_if_adel,
    input  logic        m_exc_ri,
    input  logic        m_exc_ov,
    input  logic        m_exc_sys,
    input  logic        m_exc_bp,
    input  logic        m_exc_adel,
    input  logic        m_exc_ades,
    input  logic [31:0] m_vaddr,
    input  logic        m_eret,
    input  logic        int_pending,
    input  logic [31:0] epc,
    output logic        m_ready,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        exc_bd,
    output logic [31:0] exc_badvaddr,
    output logic        eret_commit,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {IDLE, FLUSH1, FLUSH2, REDIRECT} state_t;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    state_t      state_q, state_d;
    logic        m_ready_q, m_ready_d;
    logic        exc_valid_q, exc_valid_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        exc_bd_q, exc_bd_d;
    logic [31:0] exc_badvaddr_q, exc_badvaddr_d;
    logic        eret_commit_q, eret_commit_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic is_exc;
    logic accept;

    always_comb begin
        is_exc = int_pending | m_exc_if_adel | m_exc_ri | m_exc_ov | m_exc_sys
               | m_exc_bp | m_exc_adel | m_exc_ades;
        accept = (state_q == IDLE) && m_valid && (is_exc || m_eret);

        state_d          = state_q;
        exc_code_d       = exc_code_q;
        exc_pc_d         = exc_pc_q;
        exc_bd_d         = exc_bd_q;
        exc_badvaddr_d   = exc_badvaddr_q;
        redirect_pc_d    = redirect_pc_q;
        exc_valid_d      = accept && is_exc;
        eret_commit_d    = accept && !is_exc;

        case (state_q)
            IDLE:     if (accept) state_d = FLUSH1;
            FLUSH1:   state_d = FLUSH2;
            FLUSH2:   state_d = REDIRECT;
            REDIRECT: if (redirect_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (accept) begin
            exc_pc_d       = m_pc;
            exc_bd_d       = m_bd;
            exc_badvaddr_d = 32'h0;
            redirect_pc_d  = is_exc ? EXC_VECTOR : epc;
            // Priority chain: earlier branches win; ERET carries code 0.
            if (int_pending)        exc_code_d = 5'h00;
            else if (m_exc_if_adel) begin
                exc_code_d     = 5'h04;
                exc_badvaddr_d = m_pc;
            end
            else if (m_exc_ri)      exc_code_d = 5'h0A;
            else if (m_exc_ov)      exc_code_d = 5'h0C;
            else if (m_exc_sys)     exc_code_d = 5'h08;
            else if (m_exc_bp)      exc_code_d = 5'h09;
            else if (m_exc_adel) begin
                exc_code_d     = 5'h04;
                exc_badvaddr_d = m_vaddr;
            end
            else if (m_exc_ades) begin
                exc_code_d     = 5'h05;
                exc_badvaddr_d = m_vaddr;
            end
            else                    exc_code_d = 5'h00;
        end

        // Status outputs are registered from the next state so they line up with it.
        m_ready_d        = (state_d == IDLE);
        flush_d          = (state_d != IDLE);
        redirect_valid_d = (state_d == REDIRECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            m_ready_q        <= 1'b1;
            exc_valid_q      <= 1'b0;
            exc_code_q       <= 5'h00;
            exc_pc_q         <= 32'h0;
            exc_bd_q         <= 1'b0;
            exc_badvaddr_q   <= 32'h0;
            eret_commit_q    <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
        end else begin
            state_q          <= state_d;
            m_ready_q        <= m_ready_d;
            exc_valid_q      <= exc_valid_d;
            exc_code_q       <= exc_code_d;
            exc_pc_q         <= exc_pc_d;
            exc_bd_q         <= exc_bd_d;
            exc_badvaddr_q   <= exc_badvaddr_d;
            eret_commit_q    <= eret_commit_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign m_ready        = m_ready_q;
    assign exc_valid      = exc_valid_q;
    assign exc_code       = exc_code_q;
    assign exc_pc         = exc_pc_q;
    assign exc_bd         = exc_bd_q;
    assign exc_badvaddr   = exc_badvaddr_q;
    assign eret_commit    = eret_commit_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - self-checking bench for exc_ctrl with a priority-table reference model

module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic        m_bd = 1'b0;
    logic        m_exc_if_adel = 1'b0, m_exc_ri = 1'b0, m_exc_ov = 1'b0, m_exc_sys = 1'b0;
    logic        m_exc_bp = 1'b0, m_exc_adel = 1'b0, m_exc_ades = 1'b0;
    logic [31:0] m_vaddr = 32'h0;
    logic        m_eret = 1'b0;
    logic        int_pending = 1'b0;
    logic [31:0] epc = 32'h0;
    logic        m_ready, exc_valid, exc_bd, eret_commit, flush, redirect_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, exc_badvaddr, redirect_pc;
    logic        redirect_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    exc_ctrl dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_bd(m_bd),
        .m_exc_if_adel(m_exc_if_adel), .m_exc_ri(m_exc_ri), .m_exc_ov(m_exc_ov),
        .m_exc_sys(m_exc_sys), .m_exc_bp(m_exc_bp), .m_exc_adel(m_exc_adel),
        .m_exc_ades(m_exc_ades), .m_vaddr(m_vaddr), .m_eret(m_eret),
        .int_pending(int_pending), .epc(epc), .m_ready(m_ready), .exc_valid(exc_valid),
        .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr),
        .eret_commit(eret_commit), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    // Source vector order follows architectural priority:
    // 0 int, 1 if_adel, 2 ri, 3 ov, 4 sys, 5 bp, 6 adel, 7 ades.
    function automatic int winner(input logic [7:0] s);
        for (int i = 0; i < 8; i++) if (s[i]) return i;
        return -1;
    endfunction

    function automatic logic [4:0] ref_code(input int w);
        logic [4:0] tab [8];
        tab = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};
        return (w < 0) ? 5'h00 : tab[w];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_src(input logic [7:0] s);
        int_pending   = s[0];
        m_exc_if_adel = s[1];
        m_exc_ri      = s[2];
        m_exc_ov      = s[3];
        m_exc_sys     = s[4];
        m_exc_bp      = s[5];
        m_exc_adel    = s[6];
        m_exc_ades    = s[7];
    endtask

    task automatic clear_inputs();
        m_valid = 1'b0;
        m_eret  = 1'b0;
        drive_src(8'h00);
    endtask

    // Drives one accepted event and walks it through the whole sequence,
    // stalling the redirect handshake for 'stall' cycles.
    task automatic do_event(input logic [7:0] s, input logic eret, input logic [31:0] pc,
                            input logic bd, input logic [31:0] va, input logic [31:0] epcv,
                            input int stall, input string tag);
        int          w;
        logic        is_exc;
        logic [31:0] exp_bva, exp_tgt;
        w       = winner(s);
        is_exc  = (w >= 0);
        exp_bva = (w == 1) ? pc : ((w == 6 || w == 7) ? va : 32'h0);
        exp_tgt = is_exc ? 32'hBFC00380 : epcv;

        drive_src(s); m_eret = eret; m_valid = 1'b1; m_pc = pc; m_bd = bd; m_vaddr = va; epc = epcv;
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL %s accept_ready: got %b want 1", tag, m_ready); end
        tick();
        // T+1: junk on every ignored input
        m_valid = 1'b1; drive_src(8'h10); m_pc = $urandom; m_vaddr = $urandom; epc = $urandom; redirect_ready = 1'b1;
        checks++; if (exc_valid !== is_exc) begin errors++; $display("FAIL %s exc_valid_t1: got %b want %b", tag, exc_valid, is_exc); end
        checks++; if (eret_commit !== !is_exc) begin errors++; $display("FAIL %s eret_commit_t1: got %b want %b", tag, eret_commit, !is_exc); end
        checks++; if (flush !== 1'b1 || m_ready !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL %s status_t1: got flush=%b ready=%b rv=%b want 1 0 0", tag, flush, m_ready, redirect_valid); end
        if (is_exc) begin
            checks++; if (exc_code !== ref_code(w)) begin errors++; $display("FAIL %s exc_code: got %h want %h", tag, exc_code, ref_code(w)); end
            checks++; if (exc_pc !== pc) begin errors++; $display("FAIL %s exc_pc: got %h want %h", tag, exc_pc, pc); end
            checks++; if (exc_bd !== bd) begin errors++; $display("FAIL %s exc_bd: got %b want %b", tag, exc_bd, bd); end
            checks++; if (exc_badvaddr !== exp_bva) begin errors++; $display("FAIL %s exc_badvaddr: got %h want %h", tag, exc_badvaddr, exp_bva); end
        end
        tick();
        // T+2
        checks++; if (exc_valid !== 1'b0 || eret_commit !== 1'b0) begin errors++; $display("FAIL %s pulse_width: got ev=%b ec=%b want 0 0", tag, exc_valid, eret_commit); end
        checks++; if (flush !== 1'b1 || redirect_valid !== 1'b0 || m_ready !== 1'b0) begin errors++; $display("FAIL %s status_t2: got flush=%b rv=%b ready=%b want 1 0 0", tag, flush, redirect_valid, m_ready); end
        tick();
        // T+3
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== exp_tgt || flush !== 1'b1) begin errors++; $display("FAIL %s redirect_t3: got rv=%b pc=%h flush=%b want 1 %h 1", tag, redirect_valid, redirect_pc, flush, exp_tgt); end
        redirect_ready = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            tick();
            checks++; if (redirect_valid !== 1'b1 || redirect_pc !== exp_tgt || flush !== 1'b1 || m_ready !== 1'b0 || exc_valid !== 1'b0) begin errors++; $display("FAIL %s stall_%0d: got rv=%b pc=%h flush=%b ready=%b ev=%b want 1 %h 1 0 0", tag, i, redirect_valid, redirect_pc, flush, m_ready, exc_valid, exp_tgt); end
        end
        redirect_ready = 1'b1;
        clear_inputs();
        tick();
        redirect_ready = 1'b0;
        checks++; if (m_ready !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL %s back_idle: got ready=%b flush=%b rv=%b want 1 0 0", tag, m_ready, flush, redirect_valid); end
        if (is_exc) begin
            checks++; if (exc_code !== ref_code(w) || exc_pc !== pc || exc_badvaddr !== exp_bva) begin errors++; $display("FAIL %s hold: got code=%h pc=%h bva=%h want %h %h %h", tag, exc_code, exc_pc, exc_badvaddr, ref_code(w), pc, exp_bva); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m_valid = 1'b1; m_exc_ov = 1'b1;
        tick(); tick();
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", m_ready); end
        checks++; if ({exc_valid, eret_commit, flush, redirect_valid, exc_bd} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {exc_valid, eret_commit, flush, redirect_valid, exc_bd}); end
        checks++; if ({exc_code, exc_pc, exc_badvaddr, redirect_pc} !== 101'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {exc_code, exc_pc, exc_badvaddr, redirect_pc}); end
        clear_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        do_event(8'h08, 1'b0, 32'hBFC00100, 1'b0, 32'h0, 32'h0, 0, "ov");
    endtask

    task automatic test_priority();
        do_event(8'h85, 1'b0, 32'h80000040, 1'b0, 32'h1234, 32'h0, 0, "prio");
    endtask

    task automatic test_eret();
        do_event(8'h00, 1'b1, 32'h80000500, 1'b0, 32'h0, 32'h80001234, 1, "eret");
    endtask

    task automatic test_adel_bd();
        do_event(8'h40, 1'b0, 32'h80000200, 1'b1, 32'h00000003, 32'h0, 0, "adel_bd");
    endtask

    task automatic test_stall();
        do_event(8'h10, 1'b0, 32'h80000300, 1'b0, 32'h0, 32'h0, 5, "stall");
    endtask

    task automatic test_no_event();
        m_valid = 1'b0; int_pending = 1'b1;
        tick(); tick();
        checks++; if (exc_valid !== 1'b0 || m_ready !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL int_no_valid: got ev=%b ready=%b flush=%b want 0 1 0", exc_valid, m_ready, flush); end
        int_pending = 1'b0; m_valid = 1'b1; m_pc = 32'h80000700;
        tick(); tick();
        checks++; if (exc_valid !== 1'b0 || eret_commit !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL valid_no_src: got ev=%b ec=%b flush=%b want 0 0 0", exc_valid, eret_commit, flush); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_flush2();
        m_valid = 1'b1; m_exc_bp = 1'b1; m_pc = 32'h80000800;
        tick();
        clear_inputs();
        tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (flush !== 1'b0 || m_ready !== 1'b1 || redirect_valid !== 1'b0 || exc_code !== 5'h00) begin errors++; $display("FAIL reset_flush2: got flush=%b ready=%b rv=%b code=%h want 0 1 0 00", flush, m_ready, redirect_valid, exc_code); end
        tick();
        reset = 1'b0;
        tick();
        do_event(8'h02, 1'b0, 32'h80000901, 1'b0, 32'h0, 32'h0, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [7:0] s;
        for (int n = 0; n < 40; n++) begin
            s = 8'h00;
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 3) == 0) s[b] = 1'b1;
            if (s == 8'h00 && $urandom_range(0, 1) == 0) s[$urandom_range(0, 7)] = 1'b1;
            do_event(s, 1'(s == 8'h00 || $urandom_range(0, 1) == 1), $urandom, 1'($urandom),
                     $urandom, $urandom, $urandom_range(0, 3), "rand");
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_overflow();
        test_priority();
        test_eret();
        test_adel_bd();
        test_stall();
        test_no_event();
        test_reset_flush2();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
